// File: rtl/idec_stage.sv
// Instruction decode stage: a small input FIFO feeding one registered
// decode bundle, with load-use and flag-dependency bubbles and a flush.
module idec_stage #(
    parameter int FULLW     = 32,
    parameter int REGAW     = 4,
    parameter int FLAGSW    = 4,
    parameter int BUF_DEPTH = 2,
    parameter int LR_IDX    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid_in,
    input  logic [FULLW-1:0]  i_in,
    output logic              i_ready_out,
    input  logic [FLAGSW-1:0] cpsr_in,
    input  logic              flush_in,
    input  logic              ex_ready_in,
    output logic              dec_valid_out,
    output logic [3:0]        alu_opcode_out,
    output logic [REGAW-1:0]  rn_a_out,
    output logic [REGAW-1:0]  rd_a_out,
    output logic [REGAW-1:0]  rm_a_out,
    output logic              reg_we_out,
    output logic              mem_we_out,
    output logic              ib_out,
    output logic              bl_out,
    output logic [FLAGSW-1:0] should_set_cpsr_out,
    output logic [FULLW-1:0]  bv_out,
    output logic              stall_out
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [3:0] COND_AL = 4'hE;

    // Standard ARM condition evaluation against N,Z,C,V.
    function automatic logic cond_pass(input logic [3:0] c, input logic n,
                                       input logic z, input logic cf, input logic v);
        case (c)
            4'h0:    return z;
            4'h1:    return ~z;
            4'h2:    return cf;
            4'h3:    return ~cf;
            4'h4:    return n;
            4'h5:    return ~n;
            4'h6:    return v;
            4'h7:    return ~v;
            4'h8:    return cf & ~z;
            4'h9:    return ~cf | z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return ~z & (n == v);
            4'hD:    return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    logic [FULLW-1:0] r_buf [BUF_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_is_load;

    logic [FULLW-1:0] w_head;
    logic             w_head_valid;
    logic             w_push;
    logic             w_load;
    logic             w_pass;
    logic             w_dp;
    logic             w_ls;
    logic             w_br;
    logic             w_sbit;
    logic             w_link;
    logic [REGAW-1:0] w_rn;
    logic [REGAW-1:0] w_rm;
    logic             w_lu_haz;
    logic             w_flag_haz;
    logic             w_bubble;

    assign i_ready_out  = (r_count != CW'(BUF_DEPTH));
    assign w_push       = i_valid_in & i_ready_out & ~flush_in;
    assign w_head       = r_buf[r_rptr];
    assign w_head_valid = (r_count != '0);

    // Field decode of the FIFO head.
    assign w_pass = cond_pass(w_head[31:28], cpsr_in[FLAGSW-1], cpsr_in[FLAGSW-2],
                              cpsr_in[FLAGSW-3], cpsr_in[FLAGSW-4]);
    assign w_dp   = (w_head[27:26] == 2'b00);
    assign w_ls   = (w_head[27:26] == 2'b01);
    assign w_br   = (w_head[27:25] == 3'b101);
    assign w_sbit = w_head[20];
    assign w_link = w_head[24];
    assign w_rn   = REGAW'(w_head[19:16]);
    assign w_rm   = REGAW'(w_head[3:0]);

    // Hazards only matter against a valid registered bundle and a present head.
    assign w_lu_haz   = r_is_load & reg_we_out & ((rd_a_out == w_rn) | (rd_a_out == w_rm));
    assign w_flag_haz = (should_set_cpsr_out != '0) & (w_head[31:28] != COND_AL);
    assign w_bubble   = w_head_valid & dec_valid_out & (w_lu_haz | w_flag_haz);
    assign w_load     = w_head_valid & ~w_bubble & (~dec_valid_out | ex_ready_in);

    // FIFO storage write.
    // NOTE: the buffer array is deliberately not reset; count and pointers
    // alone define which entries are live, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wptr] <= i_in;
        end
    end

    // FIFO pointers and occupancy; flush and reset empty the queue.
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_load) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Decode output register: load, bubble, drain, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_valid_out       <= 1'b0;
            alu_opcode_out      <= '0;
            rn_a_out            <= '0;
            rd_a_out            <= '0;
            rm_a_out            <= '0;
            reg_we_out          <= 1'b0;
            mem_we_out          <= 1'b0;
            ib_out              <= 1'b0;
            bl_out              <= 1'b0;
            should_set_cpsr_out <= '0;
            bv_out              <= '0;
            stall_out           <= 1'b0;
            r_is_load           <= 1'b0;
        end else if (flush_in) begin
            dec_valid_out <= 1'b0;
            stall_out     <= 1'b0;
            r_is_load     <= 1'b0;
        end else if (w_load) begin
            dec_valid_out       <= 1'b1;
            alu_opcode_out      <= w_head[24:21];
            rn_a_out            <= w_rn;
            rd_a_out            <= (w_br & w_link) ? REGAW'(LR_IDX) : REGAW'(w_head[15:12]);
            rm_a_out            <= w_rm;
            reg_we_out          <= w_pass & (w_dp | (w_ls & w_sbit) | (w_br & w_link));
            mem_we_out          <= w_pass & w_ls & ~w_sbit;
            ib_out              <= w_pass & w_br;
            bl_out              <= w_br & w_link;
            should_set_cpsr_out <= (w_pass & w_dp & w_sbit) ? '1 : '0;
            bv_out              <= {{(FULLW-26){w_head[23]}}, w_head[23:0], 2'b00};
            stall_out           <= 1'b0;
            r_is_load           <= w_ls & w_sbit;
        end else if (ex_ready_in) begin
            dec_valid_out <= 1'b0;
            stall_out     <= w_bubble;
        end else begin
            stall_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idec_stage.sv
// Directed self-checking bench for idec_stage.
module tb_idec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid_in;
    logic [31:0] i_in;
    logic        i_ready_out;
    logic [3:0]  cpsr_in;
    logic        flush_in;
    logic        ex_ready_in;
    logic        dec_valid_out;
    logic [3:0]  alu_opcode_out;
    logic [3:0]  rn_a_out;
    logic [3:0]  rd_a_out;
    logic [3:0]  rm_a_out;
    logic        reg_we_out;
    logic        mem_we_out;
    logic        ib_out;
    logic        bl_out;
    logic [3:0]  should_set_cpsr_out;
    logic [31:0] bv_out;
    logic        stall_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    idec_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_valid_in          (i_valid_in),
        .i_in                (i_in),
        .i_ready_out         (i_ready_out),
        .cpsr_in             (cpsr_in),
        .flush_in            (flush_in),
        .ex_ready_in         (ex_ready_in),
        .dec_valid_out       (dec_valid_out),
        .alu_opcode_out      (alu_opcode_out),
        .rn_a_out            (rn_a_out),
        .rd_a_out            (rd_a_out),
        .rm_a_out            (rm_a_out),
        .reg_we_out          (reg_we_out),
        .mem_we_out          (mem_we_out),
        .ib_out              (ib_out),
        .bl_out              (bl_out),
        .should_set_cpsr_out (should_set_cpsr_out),
        .bv_out              (bv_out),
        .stall_out           (stall_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_R2   = 32'hE0812003;
    localparam logic [31:0] LDR_R4   = 32'hE5954000;
    localparam logic [31:0] ADD_R6   = 32'hE0846007;
    localparam logic [31:0] BL_P8    = 32'hEB000002;
    localparam logic [31:0] B_M8     = 32'hEAFFFFFE;
    localparam logic [31:0] ADDEQ    = 32'h02812003;
    localparam logic [31:0] ADDEQS   = 32'h02912003;

    initial begin
        rst_n = 1'b0; i_valid_in = 1'b0; i_in = '0; cpsr_in = 4'b0000;
        flush_in = 1'b0; ex_ready_in = 1'b1;
        step(); step();
        check("rst_valid", 32'(dec_valid_out), 32'd0);
        check("rst_ready", 32'(i_ready_out), 32'd1);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_regwe", 32'(reg_we_out), 32'd0);
        check("rst_bv", bv_out, 32'd0);
        rst_n = 1'b1;
        step();

        // ADD r2,r1,r3
        i_valid_in = 1'b1; i_in = ADD_R2; step();
        i_valid_in = 1'b0;
        check("add_latency", 32'(dec_valid_out), 32'd0);
        step();
        check("add_valid", 32'(dec_valid_out), 32'd1);
        check("add_opc", 32'(alu_opcode_out), 32'h4);
        check("add_rn", 32'(rn_a_out), 32'd1);
        check("add_rd", 32'(rd_a_out), 32'd2);
        check("add_rm", 32'(rm_a_out), 32'd3);
        check("add_regwe", 32'(reg_we_out), 32'd1);
        check("add_memwe", 32'(mem_we_out), 32'd0);
        check("add_sset", 32'(should_set_cpsr_out), 32'd0);
        step();
        check("add_drain", 32'(dec_valid_out), 32'd0);

        // Load-use: LDR r4,[r5] then ADD r6,r4,r7
        i_valid_in = 1'b1; i_in = LDR_R4; step();
        i_in = ADD_R6; step();
        i_valid_in = 1'b0;
        check("ldr_valid", 32'(dec_valid_out), 32'd1);
        check("ldr_regwe", 32'(reg_we_out), 32'd1);
        check("ldr_memwe", 32'(mem_we_out), 32'd0);
        check("ldr_rd", 32'(rd_a_out), 32'd4);
        step();
        check("lu_bubble_valid", 32'(dec_valid_out), 32'd0);
        check("lu_bubble_stall", 32'(stall_out), 32'd1);
        step();
        check("lu_add_valid", 32'(dec_valid_out), 32'd1);
        check("lu_add_rd", 32'(rd_a_out), 32'd6);
        check("lu_stall_clear", 32'(stall_out), 32'd0);
        step();

        // BL +8 and B -8
        i_valid_in = 1'b1; i_in = BL_P8; step();
        i_in = B_M8; step();
        i_valid_in = 1'b0;
        check("bl_ib", 32'(ib_out), 32'd1);
        check("bl_bl", 32'(bl_out), 32'd1);
        check("bl_rd", 32'(rd_a_out), 32'd14);
        check("bl_bv", bv_out, 32'h00000008);
        check("bl_regwe", 32'(reg_we_out), 32'd1);
        step();
        check("b_valid", 32'(dec_valid_out), 32'd1);
        check("b_ib", 32'(ib_out), 32'd1);
        check("b_bl", 32'(bl_out), 32'd0);
        check("b_regwe", 32'(reg_we_out), 32'd0);
        check("b_bv", bv_out, 32'hFFFFFFF8);
        step();

        // ADDEQ with Z=0 fails its condition
        cpsr_in = 4'b0000;
        i_valid_in = 1'b1; i_in = ADDEQ; step();
        i_valid_in = 1'b0; step();
        check("eqf_valid", 32'(dec_valid_out), 32'd1);
        check("eqf_regwe", 32'(reg_we_out), 32'd0);
        check("eqf_memwe", 32'(mem_we_out), 32'd0);
        check("eqf_ib", 32'(ib_out), 32'd0);
        check("eqf_sset", 32'(should_set_cpsr_out), 32'd0);
        step();

        // Flag hazard: ADDEQS then ADDEQ with Z=1
        cpsr_in = 4'b0100;
        i_valid_in = 1'b1; i_in = ADDEQS; step();
        i_in = ADDEQ; step();
        i_valid_in = 1'b0;
        check("fh_first_sset", 32'(should_set_cpsr_out), 32'hF);
        check("fh_first_regwe", 32'(reg_we_out), 32'd1);
        step();
        check("fh_bubble_valid", 32'(dec_valid_out), 32'd0);
        check("fh_bubble_stall", 32'(stall_out), 32'd1);
        step();
        check("fh_second_valid", 32'(dec_valid_out), 32'd1);
        check("fh_second_sset", 32'(should_set_cpsr_out), 32'd0);
        check("fh_second_regwe", 32'(reg_we_out), 32'd1);
        ex_ready_in = 1'b0; step();
        check("hold_valid", 32'(dec_valid_out), 32'd1);
        check("hold_rd", 32'(rd_a_out), 32'd2);
        ex_ready_in = 1'b1; step();
        check("hold_release", 32'(dec_valid_out), 32'd0);
        cpsr_in = 4'b0000;

        // Fill with execute stalled, then flush
        ex_ready_in = 1'b0;
        i_valid_in = 1'b1; i_in = ADD_R2;
        step();
        check("fill1_ready", 32'(i_ready_out), 32'd1);
        step();
        check("fill2_ready", 32'(i_ready_out), 32'd1);
        step();
        check("fill3_ready", 32'(i_ready_out), 32'd0);
        check("fill3_valid", 32'(dec_valid_out), 32'd1);
        i_valid_in = 1'b0; flush_in = 1'b1; step();
        flush_in = 1'b0;
        check("flush_valid", 32'(dec_valid_out), 32'd0);
        check("flush_ready", 32'(i_ready_out), 32'd1);
        ex_ready_in = 1'b1;
        i_valid_in = 1'b1; flush_in = 1'b1; step();
        i_valid_in = 1'b0; flush_in = 1'b0; step();
        check("flush_drop_push", 32'(dec_valid_out), 32'd0);

        // Reset during a load-use bubble
        i_valid_in = 1'b1; i_in = LDR_R4; step();
        i_in = ADD_R6; step();
        i_valid_in = 1'b0; step();
        check("rb_stall", 32'(stall_out), 32'd1);
        rst_n = 1'b0; step();
        check("rb_valid", 32'(dec_valid_out), 32'd0);
        check("rb_stall0", 32'(stall_out), 32'd0);
        check("rb_rd", 32'(rd_a_out), 32'd0);
        check("rb_regwe", 32'(reg_we_out), 32'd0);
        check("rb_ready", 32'(i_ready_out), 32'd1);
        rst_n = 1'b1; step(); step();
        check("rb_no_reissue", 32'(dec_valid_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
